// File: rtl/spi_dac_driver_pkg.sv
// Shared constants, FSM encoding and frame-building helper for the Pmod DA2 SPI driver.
package spi_dac_driver_pkg;

    localparam int         DAC_FRAME_BITS = 16;
    localparam logic [3:0] DAC_CTRL_BITS  = 4'b0000;
    localparam int         SAMPLE_WIDTH   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Two's complement input becomes offset binary by flipping the sign bit.
    function automatic logic [DAC_FRAME_BITS-1:0] make_frame(
        input logic [SAMPLE_WIDTH-1:0] sample,
        input logic                    signed_in
    );
        return {DAC_CTRL_BITS, sample[SAMPLE_WIDTH-1] ^ signed_in, sample[SAMPLE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/spi_dac_driver_if.sv
// Sample input and DAC-side output bundle of the SPI DAC driver.
interface spi_dac_driver_if;
    import spi_dac_driver_pkg::*;

    logic [SAMPLE_WIDTH-1:0] sample_data;
    logic                    sample_valid;
    logic                    dac_sclk;
    logic                    dac_sync_n;
    logic                    dac_din;
    logic                    busy;
    logic                    overrun;

    modport master (
        output sample_data, sample_valid,
        input  dac_sclk, dac_sync_n, dac_din, busy, overrun
    );

    modport slave (
        input  sample_data, sample_valid,
        output dac_sclk, dac_sync_n, dac_din, busy, overrun
    );

endinterface

// File: rtl/spi_dac_driver_sclk_divider.sv
// Bit-period divider: registered SCLK level plus a tick on the last clk of each bit period.
module sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic sclk_level_o,
    output logic bit_tick_o
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          sclk_q, sclk_d;

    // SCLK is registered from the next count so it lines up with div_cnt.
    always_comb begin
        div_cnt_d = '0;
        if (run_i && !clear_i) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
        end
        sclk_d = run_i ? (div_cnt_d < HALF) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_level_o = sclk_q;
    assign bit_tick_o   = (div_cnt_q == LAST);

endmodule

// File: rtl/spi_dac_driver.sv
// Serialises 12-bit samples into 16-bit SPI frames for a DAC121S101, with a one-deep holding register.
module spi_dac_driver
    import spi_dac_driver_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int IDLE_CYCLES = 2,
    parameter bit SIGNED_IN   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    spi_dac_driver_if.slave   dac_bus
);

    localparam int                GW       = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [GW-1:0]     GAP_LAST = GW'(IDLE_CYCLES - 1);
    localparam logic [3:0]        BIT_LAST = 4'(DAC_FRAME_BITS - 1);

    state_e                    state_q, state_d;
    logic [DAC_FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic [SAMPLE_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic                      pend_full_q, pend_full_d;
    logic                      sync_n_q, sync_n_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic                      load, bypass, bit_tick, sclk_level;

    sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (load),
        .run_i        (state_d == ST_SHIFT),
        .sclk_level_o (sclk_level),
        .bit_tick_o   (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pend_data_d = pend_data_q;
        pend_full_d = pend_full_q;
        sync_n_d    = 1'b1;
        overrun_d   = 1'b0;
        load        = 1'b0;
        bypass      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q || dac_bus.sample_valid) begin
                    load   = 1'b1;
                    bypass = !pend_full_q;
                end
            end
            ST_SHIFT: begin
                sync_n_d = 1'b0;
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                        sync_n_d  = 1'b1;
                        shift_d   = '0;
                    end else begin
                        shift_d   = {shift_q[DAC_FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (pend_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shift_d     = make_frame(bypass ? dac_bus.sample_data : pend_data_q, SIGNED_IN);
            bit_cnt_d   = '0;
            sync_n_d    = 1'b0;
            state_d     = ST_SHIFT;
            pend_full_d = 1'b0;
        end

        // A sample arriving while the register is being drained simply refills it.
        if (dac_bus.sample_valid && !bypass) begin
            pend_data_d = dac_bus.sample_data;
            pend_full_d = 1'b1;
            overrun_d   = pend_full_q && !load;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            pend_data_q <= '0;
            pend_full_q <= 1'b0;
            sync_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pend_data_q <= pend_data_d;
            pend_full_q <= pend_full_d;
            sync_n_q    <= sync_n_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dac_bus.dac_sclk   = sclk_level;
    assign dac_bus.dac_sync_n = sync_n_q;
    assign dac_bus.dac_din    = shift_q[DAC_FRAME_BITS-1];
    assign dac_bus.busy       = busy_q;
    assign dac_bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_dac_driver.sv
// Directed bench for spi_dac_driver: a DAC-side receiver model captures frames on falling SCLK.
module tb_spi_dac_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_dac_driver_if bus0 ();
    spi_dac_driver_if bus1 ();

    spi_dac_driver #(.CLK_DIV(4), .IDLE_CYCLES(2), .SIGNED_IN(1'b1)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .dac_bus (bus0)
    );

    spi_dac_driver #(.CLK_DIV(4), .IDLE_CYCLES(2), .SIGNED_IN(1'b0)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .dac_bus (bus1)
    );

    typedef struct {
        logic [15:0] data;
        int          bits;
        int          lowLen;
        int          startCyc;
        int          riseCyc;
    } frame_t;

    typedef struct {
        logic [11:0] sample;
        logic [15:0] expFrame;
    } vec_t;

    frame_t      frames[$];
    logic [15:0] frames1[$];
    int checkCnt = 0;
    int passCnt  = 0;
    int overrunCnt = 0, lastOverrunCyc = -1, busyCyc = 0, busyFallCyc = -1, lastSendCyc = -1;

    // DAC receiver model for dut0: shift din on falling SCLK while SYNC is low.
    logic        prevSclk = 1'b1, prevSync = 1'b1, prevBusy = 1'b0;
    logic [15:0] shiftIn = '0;
    int          bitCnt = 0, lowLen = 0, startCyc = 0;

    always @(negedge clk) begin
        if (bus0.dac_sync_n === 1'b0) begin
            if (prevSync) begin
                lowLen = 0; bitCnt = 0; shiftIn = '0; startCyc = cyc;
            end
            lowLen++;
            if (prevSclk && bus0.dac_sclk === 1'b0) begin
                shiftIn = {shiftIn[14:0], bus0.dac_din};
                bitCnt++;
            end
        end else if (prevSync === 1'b0) begin
            frames.push_back('{shiftIn, bitCnt, lowLen, startCyc, cyc});
        end
        if (prevBusy && bus0.busy === 1'b0) busyFallCyc = cyc;
        if (bus0.busy === 1'b1) busyCyc++;
        if (bus0.overrun === 1'b1) begin
            overrunCnt++;
            lastOverrunCyc = cyc;
        end
        prevSclk = (bus0.dac_sclk === 1'b1);
        prevSync = (bus0.dac_sync_n !== 1'b0);
        prevBusy = (bus0.busy === 1'b1);
    end

    // Lighter receiver for the unsigned-pass-through instance.
    logic        prevSclk1 = 1'b1, prevSync1 = 1'b1;
    logic [15:0] shiftIn1 = '0;

    always @(negedge clk) begin
        if (bus1.dac_sync_n === 1'b0) begin
            if (prevSclk1 && bus1.dac_sclk === 1'b0) shiftIn1 = {shiftIn1[14:0], bus1.dac_din};
        end else if (prevSync1 === 1'b0) begin
            frames1.push_back(shiftIn1);
        end
        prevSclk1 = (bus1.dac_sclk === 1'b1);
        prevSync1 = (bus1.dac_sync_n !== 1'b0);
    end

    function automatic logic [15:0] tbCode(input logic [11:0] s);
        return {4'b0000, ~s[11], s[10:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int which, input logic [11:0] s);
        @(posedge clk); #1;
        lastSendCyc = cyc;
        if (which == 0) begin
            bus0.sample_data = s; bus0.sample_valid = 1'b1;
        end else begin
            bus1.sample_data = s; bus1.sample_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus0.sample_valid = 1'b0;
        bus1.sample_valid = 1'b0;
    endtask

    task automatic waitFrames(input int n, input int budget, input string name);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk); k++;
        end
        checkOutput(name, 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int k = 0;
        while (bus0.busy !== 1'b0 && k < budget) begin
            @(posedge clk); k++;
        end
        @(posedge clk); #1;
        checkOutput(name, 32'(bus0.busy === 1'b0), 32'd1);
    endtask

    task automatic popFrame(output frame_t f);
        if (frames.size() > 0) f = frames.pop_front();
        else f = '{16'hxxxx, -1, -1, -1, -1};
    endtask

    vec_t   vecs[6];
    frame_t f, fa, fb;
    int     base, busyBase, k;

    initial begin
        vecs[0] = '{12'h123, 16'h0923};
        vecs[1] = '{12'h800, 16'h0000};
        vecs[2] = '{12'h000, 16'h0800};
        vecs[3] = '{12'h7FF, 16'h0FFF};
        vecs[4] = '{12'hFFF, 16'h07FF};
        vecs[5] = '{12'h5A5, 16'h0DA5};

        bus0.sample_data = '0; bus0.sample_valid = 1'b0;
        bus1.sample_data = '0; bus1.sample_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset sync_n", 32'(bus0.dac_sync_n), 32'd1);
        checkOutput("reset sclk", 32'(bus0.dac_sclk), 32'd1);
        checkOutput("reset din", 32'(bus0.dac_din), 32'd0);
        checkOutput("reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset overrun", 32'(bus0.overrun), 32'd0);

        // Single frames from the vector table, each one run to idle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, vecs[i].sample);
            checkOutput($sformatf("v%0d start sync_n", i), 32'(bus0.dac_sync_n), 32'd0);
            checkOutput($sformatf("v%0d start sclk", i), 32'(bus0.dac_sclk), 32'd1);
            checkOutput($sformatf("v%0d start din", i), 32'(bus0.dac_din), 32'(vecs[i].expFrame[15]));
            waitFrames(1, 200, $sformatf("v%0d frame timeout", i));
            waitIdle(20, $sformatf("v%0d idle timeout", i));
            popFrame(f);
            checkOutput($sformatf("v%0d data", i), 32'(f.data), 32'(vecs[i].expFrame));
            checkOutput($sformatf("v%0d falling edges", i), 32'(f.bits), 32'd16);
            checkOutput($sformatf("v%0d sync low cycles", i), 32'(f.lowLen), 32'd64);
            checkOutput($sformatf("v%0d busy tail", i), 32'(busyFallCyc - f.riseCyc), 32'd2);
        end

        // Unsigned pass-through instance.
        applyStimulus(1, 12'h800);
        k = 0;
        while (frames1.size() < 1 && k < 200) begin @(posedge clk); k++; end
        checkOutput("unsigned 800", 32'((frames1.size() > 0) ? frames1.pop_front() : 16'hxxxx), 32'h0800);
        applyStimulus(1, 12'h123);
        k = 0;
        while (frames1.size() < 1 && k < 200) begin @(posedge clk); k++; end
        checkOutput("unsigned 123", 32'((frames1.size() > 0) ? frames1.pop_front() : 16'hxxxx), 32'h0123);

        // Back-to-back: second sample lands mid-frame and follows after the gap.
        base = overrunCnt;
        applyStimulus(0, 12'h111);
        repeat (8) @(posedge clk);
        applyStimulus(0, 12'h222);
        waitFrames(2, 300, "b2b frame timeout");
        waitIdle(20, "b2b idle timeout");
        popFrame(fa);
        popFrame(fb);
        checkOutput("b2b first", 32'(fa.data), 32'(tbCode(12'h111)));
        checkOutput("b2b second", 32'(fb.data), 32'(tbCode(12'h222)));
        checkOutput("b2b gap", 32'(fb.startCyc - fa.riseCyc), 32'd2);
        checkOutput("b2b no overrun", 32'(overrunCnt - base), 32'd0);

        // Overrun: A at 0, B at 5, C at 10; B is overwritten by C.
        base = overrunCnt;
        applyStimulus(0, 12'hA0A);
        repeat (3) @(posedge clk);
        applyStimulus(0, 12'hB0B);
        repeat (3) @(posedge clk);
        applyStimulus(0, 12'hC0C);
        waitFrames(2, 300, "ovr frame timeout");
        waitIdle(20, "ovr idle timeout");
        popFrame(fa);
        popFrame(fb);
        checkOutput("ovr first", 32'(fa.data), 32'(tbCode(12'hA0A)));
        checkOutput("ovr second", 32'(fb.data), 32'(tbCode(12'hC0C)));
        checkOutput("ovr pulse count", 32'(overrunCnt - base), 32'd1);
        checkOutput("ovr pulse cycle", 32'(lastOverrunCyc - lastSendCyc), 32'd1);
        repeat (100) @(posedge clk);
        checkOutput("ovr no extra frame", 32'(frames.size()), 32'd0);

        // Reset at cycle 30 of a frame aborts it cleanly.
        applyStimulus(0, 12'h456);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort sync_n", 32'(bus0.dac_sync_n), 32'd1);
        checkOutput("abort sclk", 32'(bus0.dac_sclk), 32'd1);
        checkOutput("abort busy", 32'(bus0.busy), 32'd0);
        repeat (2) @(posedge clk);
        popFrame(f);
        checkOutput("abort partial", 32'(f.bits >= 0 && f.bits < 16), 32'd1);
        applyStimulus(0, 12'h3C3);
        waitFrames(1, 200, "post-abort frame timeout");
        waitIdle(20, "post-abort idle timeout");
        popFrame(f);
        checkOutput("post-abort data", 32'(f.data), 32'h0BC3);
        checkOutput("post-abort edges", 32'(f.bits), 32'd16);

        // Real pacing at the 44.1 kSa/s period.
        base = overrunCnt;
        busyBase = busyCyc;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 12'(i * 397 + 5));
            repeat (2265) @(posedge clk);
        end
        checkOutput("pace frame count", 32'(frames.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            popFrame(f);
            checkOutput($sformatf("pace data %0d", i), 32'(f.data), 32'(tbCode(12'(i * 397 + 5))));
        end
        checkOutput("pace no overrun", 32'(overrunCnt - base), 32'd0);
        checkOutput("pace busy cycles", 32'(busyCyc - busyBase), 32'd660);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
